// File: rtl/multiplier.sv
// Sequential shift-and-add multiplier: WIDTH-bit operands, 2*WIDTH-bit
// product after WIDTH iteration cycles. It uses the same Go/ResultValid
// handshake as the restoring divider.
// Optional build macro: MULTIPLIER_SIGNED_EN selects two's-complement
// operands and product. In that mode the final iteration subtracts the
// multiplicand. With the macro undefined, the unit is unsigned only and
// has no subtract path.
module multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   Go,
  input  logic [WIDTH-1:0]       Multiplicand,
  input  logic [WIDTH-1:0]       Multiplier,
  output logic [2*WIDTH-1:0]     Product,
  output logic                   ResultValid,
  output logic                   Busy
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   mreg;
  logic [WIDTH-1:0]   qreg;
  logic [WIDTH:0]     acc;
  logic [CNT_W-1:0]   cnt;
  logic               last_iter;
  logic               go_accept;
  logic [WIDTH:0]     ext;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     acc_shift;
  logic [WIDTH-1:0]   qreg_shift;

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign go_accept = Go && ((state == IDLE) || (state == DONE));

  // State register; reset drops straight to IDLE without a clock.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state decode and status outputs; Go is ignored while calculating.
  always_comb begin
    state_next  = state;
    Busy        = 1'b0;
    ResultValid = 1'b0;
    unique case (state)
      IDLE: begin
        if (Go) state_next = CALC;
      end
      CALC: begin
        Busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        ResultValid = 1'b1;
        if (Go) state_next = CALC;
      end
      default: state_next = IDLE;
    endcase
  end

  // One iteration: conditional add (or subtract), then shift {acc,qreg} right.
  always_comb begin
`ifdef MULTIPLIER_SIGNED_EN
    ext = {mreg[WIDTH-1], mreg};
    if (qreg[0]) sum = last_iter ? (acc - ext) : (acc + ext);
    else         sum = acc;
    acc_shift = {sum[WIDTH], sum[WIDTH:1]};
`else
    ext = {1'b0, mreg};
    sum = qreg[0] ? (acc + ext) : acc;
    acc_shift = {1'b0, sum[WIDTH:1]};
`endif
    qreg_shift = {sum[0], qreg[WIDTH-1:1]};
  end

  // Operand capture, iteration registers and the held Product.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      mreg    <= '0;
      qreg    <= '0;
      acc     <= '0;
      cnt     <= '0;
      Product <= '0;
    end else if (go_accept) begin
      mreg <= Multiplicand;
      qreg <= Multiplier;
      acc  <= '0;
      cnt  <= '0;
    end else if (state == CALC) begin
      acc  <= acc_shift;
      qreg <= qreg_shift;
      cnt  <= cnt + CNT_W'(1);
      if (last_iter) Product <= {acc_shift[WIDTH-1:0], qreg_shift};
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier (WIDTH=4). A cycle-level behavioural
// model predicts Busy/ResultValid/Product every cycle, and directed
// cases pin known products.
module tb_multiplier;

  localparam int W = 4;

  logic           Clock = 1'b0;
  logic           Reset_n = 1'b0;
  logic           Go = 1'b0;
  logic [W-1:0]   Multiplicand = '0;
  logic [W-1:0]   Multiplier = '0;
  logic [2*W-1:0] Product;
  logic           ResultValid;
  logic           Busy;

  int checks = 0;
  int errors = 0;

  multiplier #(.WIDTH(W)) dut (
    .Clock(Clock),
    .Reset_n(Reset_n),
    .Go(Go),
    .Multiplicand(Multiplicand),
    .Multiplier(Multiplier),
    .Product(Product),
    .ResultValid(ResultValid),
    .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic product in the configured number system.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
`ifdef MULTIPLIER_SIGNED_EN
    p = longint'($signed(a)) * longint'($signed(b));
`else
    p = longint'(a) * longint'(b);
`endif
    return p[2*W-1:0];
  endfunction

  // Behavioural model: an accepted Go yields W busy cycles, then the product.
  int             remaining = 0;
  logic           exp_valid = 1'b0;
  logic [2*W-1:0] exp_prod = '0;
  logic [2*W-1:0] pending = '0;

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      remaining <= 0;
      exp_valid <= 1'b0;
      exp_prod  <= '0;
    end else if (remaining > 0) begin
      remaining <= remaining - 1;
      if (remaining == 1) begin
        exp_valid <= 1'b1;
        exp_prod  <= pending;
      end
    end else if (Go) begin
      pending   <= ref_mul(Multiplicand, Multiplier);
      remaining <= W;
      exp_valid <= 1'b0;
    end
  end

  always @(negedge Clock) begin
    check("busy", 16'(Busy), 16'(remaining > 0));
    check("valid", 16'(ResultValid), 16'(exp_valid));
    check("product", 16'(Product), 16'(exp_prod));
  end

  task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] q);
    @(negedge Clock);
    Go = 1'b1;
    Multiplicand = m;
    Multiplier = q;
    @(posedge Clock);
    #1 Go = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!ResultValid && n < 20) begin
      @(posedge Clock);
      n++;
      #1;
    end
  endtask

  logic [2*W-1:0] lit_a, lit_b, lit_c, lit_ff, lit_79;
  logic [W-1:0]   ma, qa, mb, qb, mc, qc;
  int n;

  initial begin
`ifdef MULTIPLIER_SIGNED_EN
    ma = 4'h8; qa = 4'h8; lit_a = 8'h40;
    mb = 4'hD; qb = 4'h5; lit_b = 8'hF1;
    mc = 4'h7; qc = 4'hF; lit_c = 8'hF9;
    lit_ff = 8'h01;
    lit_79 = 8'hCF;
`else
    ma = 4'hF; qa = 4'hF; lit_a = 8'hE1;
    mb = 4'h7; qb = 4'h9; lit_b = 8'h3F;
    mc = 4'h0; qc = 4'hD; lit_c = 8'h00;
    lit_ff = 8'hE1;
    lit_79 = 8'h3F;
`endif
    #3;
    check("reset_product", 16'(Product), 16'h0);
    check("reset_valid", 16'(ResultValid), 16'h0);
    check("reset_busy", 16'(Busy), 16'h0);
    @(negedge Clock);
    Reset_n = 1'b1;

    // Directed products with latency.
    start_op(ma, qa); wait_done(n);
    check("lat_a", 16'(n), 16'd4); check("prod_a", 16'(Product), 16'(lit_a));
    start_op(mb, qb); wait_done(n);
    check("lat_b", 16'(n), 16'd4); check("prod_b", 16'(Product), 16'(lit_b));
    start_op(mc, qc); wait_done(n);
    check("lat_c", 16'(n), 16'd4); check("prod_c", 16'(Product), 16'(lit_c));
`ifdef MULTIPLIER_SIGNED_EN
    start_op(4'h8, 4'h7); wait_done(n);
    check("prod_d", 16'(Product), 16'h00C8);
`endif

    // Go pulse and operand changes during CALC have no effect.
    start_op(4'hF, 4'hF);
    @(negedge Clock);
    Go = 1'b1; Multiplicand = 4'h1; Multiplier = 4'h1;
    @(negedge Clock);
    Go = 1'b0; Multiplicand = 4'h2; Multiplier = 4'h3;
    n = 1;
    while (!ResultValid && n < 20) begin
      @(posedge Clock); n++; #1;
    end
    check("ignore_lat", 16'(n), 16'd4);
    check("ignore_prod", 16'(Product), 16'(lit_ff));
    @(posedge Clock); #1;
    check("ignore_norestart", 16'(Busy), 16'h0);

    // Back-to-back: Go already high when DONE is entered.
    start_op(4'h7, 4'h9);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Go = 1'b1; Multiplicand = 4'h3; Multiplier = 4'h5;
    @(posedge Clock); #1;
    check("b2b_valid1", 16'(ResultValid), 16'h1);
    check("b2b_prod1", 16'(Product), 16'(lit_79));
    @(posedge Clock); #1;
    check("b2b_valid0", 16'(ResultValid), 16'h0);
    check("b2b_busy", 16'(Busy), 16'h1);
    check("b2b_hold", 16'(Product), 16'(lit_79));
    Go = 1'b0;
    wait_done(n);
    check("b2b_lat", 16'(n), 16'd4);
    check("b2b_prod2", 16'(Product), 16'h000F);

    // Reset at Cnt=2 clears immediately without a clock.
    start_op(4'hF, 4'hF);
    @(posedge Clock);
    @(posedge Clock);
    #2 Reset_n = 1'b0;
    #1;
    check("midrst_product", 16'(Product), 16'h0);
    check("midrst_valid", 16'(ResultValid), 16'h0);
    check("midrst_busy", 16'(Busy), 16'h0);
    #1 Reset_n = 1'b1;
    start_op(4'h2, 4'h6); wait_done(n);
    check("postrst_lat", 16'(n), 16'd4);
    check("postrst_prod", 16'(Product), 16'h000C);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 800; i++) begin
      @(negedge Clock);
      Go = ($urandom_range(0, 3) == 0);
      Multiplicand = W'($urandom);
      Multiplier = W'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #1 Reset_n = 1'b0;
        #2 Reset_n = 1'b1;
      end
    end
    @(negedge Clock);
    Go = 1'b0;
    repeat (6) @(negedge Clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
